// File: rtl/writeback_arbiter.sv
// Register-file writeback arbiter: ALU results win outright, memory results queue in a FIFO,
// and a 32-bit pending scoreboard tracks outstanding long-latency destinations.
// Optional forwarding outputs are enabled by defining WB_BYPASS_EN.
module writeback_arbiter #(
  parameter int FIFO_DEPTH = 4,
  parameter int WORD_W     = 32
) (
  input  logic              clk_cpu,
  input  logic              reset,
  input  logic              alu_valid,
  input  logic [4:0]        alu_rd,
  input  logic [WORD_W-1:0] alu_data,
  input  logic              mem_valid,
  input  logic [4:0]        mem_rd,
  input  logic [WORD_W-1:0] mem_data,
  output logic              mem_ready,
  input  logic              issue_en,
  input  logic [4:0]        issue_rd,
  input  logic [4:0]        chk_adrs_a,
  input  logic [4:0]        chk_adrs_b,
  output logic              busy_a,
  output logic              busy_b,
  output logic [4:0]        wr_adrs,
  output logic [WORD_W-1:0] wr_data,
  output logic              wr_en
`ifdef WB_BYPASS_EN
  ,
  output logic              fwd_hit_a,
  output logic              fwd_hit_b,
  output logic [WORD_W-1:0] fwd_a,
  output logic [WORD_W-1:0] fwd_b
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [4:0]        fifo_rd   [FIFO_DEPTH];
  logic [WORD_W-1:0] fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;

  logic              alu_win, push, pop;
  logic [4:0]        head_rd;
  logic [WORD_W-1:0] head_data;

  logic              sel_en, sel_from_mem;
  logic [4:0]        sel_adrs;
  logic [WORD_W-1:0] sel_data;
  logic              wr_from_mem;

  logic [31:0]       pending, pending_nxt;
  logic              raw_busy_a, raw_busy_b;

  assign head_rd   = fifo_rd[rd_ptr];
  assign head_data = fifo_data[rd_ptr];
  assign alu_win   = alu_valid && (alu_rd != 5'd0);
  assign mem_ready = (count != CNT_W'(FIFO_DEPTH));
  assign push      = mem_valid && mem_ready;
  assign pop       = !alu_win && (count != '0);

  // NOTE: the entry storage is not reset; the reset pointers and count define what is valid.
  always_ff @(posedge clk_cpu) begin
    if (push) begin
      fifo_rd[wr_ptr]   <= mem_rd;
      fifo_data[wr_ptr] <= mem_data;
    end
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_cpu or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Source select; a popped entry with rd=0 is consumed but never written.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    sel_en       = 1'b0;
    sel_from_mem = 1'b0;
    sel_adrs     = 5'd0;
    sel_data     = '0;
    if (alu_win) begin
      sel_en   = 1'b1;
      sel_adrs = alu_rd;
      sel_data = alu_data;
    end else if (pop && (head_rd != 5'd0)) begin
      sel_en       = 1'b1;
      sel_from_mem = 1'b1;
      sel_adrs     = head_rd;
      sel_data     = head_data;
    end
  end

  always_ff @(posedge clk_cpu or posedge reset) begin
    if (reset) begin
      wr_en       <= 1'b0;
      wr_from_mem <= 1'b0;
      wr_adrs     <= 5'd0;
      wr_data     <= '0;
    end else begin
      wr_en       <= sel_en;
      wr_from_mem <= sel_from_mem;
      wr_adrs     <= sel_adrs;
      wr_data     <= sel_data;
    end
  end

  // The set is applied after the clear so a same-edge collision leaves the bit set.
  always_comb begin
    pending_nxt = pending;
    if (wr_en && wr_from_mem) pending_nxt[wr_adrs] = 1'b0;
    if (issue_en && (issue_rd != 5'd0)) pending_nxt[issue_rd] = 1'b1;
  end

  always_ff @(posedge clk_cpu or posedge reset) begin
    if (reset) pending <= '0;
    else       pending <= pending_nxt;
  end

  assign raw_busy_a = (chk_adrs_a != 5'd0) && pending[chk_adrs_a];
  assign raw_busy_b = (chk_adrs_b != 5'd0) && pending[chk_adrs_b];

`ifdef WB_BYPASS_EN
  assign fwd_hit_a = wr_en && (wr_adrs == chk_adrs_a) && (chk_adrs_a != 5'd0);
  assign fwd_hit_b = wr_en && (wr_adrs == chk_adrs_b) && (chk_adrs_b != 5'd0);
  assign fwd_a     = wr_data;
  assign fwd_b     = wr_data;
  assign busy_a    = raw_busy_a && !fwd_hit_a;
  assign busy_b    = raw_busy_b && !fwd_hit_b;
`else
  assign busy_a    = raw_busy_a;
  assign busy_b    = raw_busy_b;
`endif

endmodule

// File: tb/tb_writeback_arbiter.sv
// Self-checking bench for writeback_arbiter: directed scenarios plus random traffic,
// checked against a queue/bit-array reference model. Honors WB_BYPASS_EN.
module tb_writeback_arbiter;

  localparam int DEPTH = 4;
  localparam int W     = 32;

  logic         clk_cpu = 1'b0;
  logic         reset;
  logic         alu_valid, mem_valid, issue_en;
  logic [4:0]   alu_rd, mem_rd, issue_rd, chk_adrs_a, chk_adrs_b;
  logic [W-1:0] alu_data, mem_data;
  logic         mem_ready, busy_a, busy_b, wr_en;
  logic [4:0]   wr_adrs;
  logic [W-1:0] wr_data;
`ifdef WB_BYPASS_EN
  logic         fwd_hit_a, fwd_hit_b;
  logic [W-1:0] fwd_a, fwd_b;
`endif

  writeback_arbiter #(.FIFO_DEPTH(DEPTH), .WORD_W(W)) dut (
    .clk_cpu    (clk_cpu),
    .reset      (reset),
    .alu_valid  (alu_valid),
    .alu_rd     (alu_rd),
    .alu_data   (alu_data),
    .mem_valid  (mem_valid),
    .mem_rd     (mem_rd),
    .mem_data   (mem_data),
    .mem_ready  (mem_ready),
    .issue_en   (issue_en),
    .issue_rd   (issue_rd),
    .chk_adrs_a (chk_adrs_a),
    .chk_adrs_b (chk_adrs_b),
    .busy_a     (busy_a),
    .busy_b     (busy_b),
    .wr_adrs    (wr_adrs),
    .wr_data    (wr_data),
    .wr_en      (wr_en)
`ifdef WB_BYPASS_EN
    ,
    .fwd_hit_a  (fwd_hit_a),
    .fwd_hit_b  (fwd_hit_b),
    .fwd_a      (fwd_a),
    .fwd_b      (fwd_b)
`endif
  );

  always #5 clk_cpu = ~clk_cpu;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  // Reference model: arrival-ordered queue, pending flags, and the write now on wr_*.
  typedef struct {
    logic [4:0]   rd;
    logic [W-1:0] data;
  } ent_t;

  ent_t         mq[$];
  bit           pend[32];
  bit           exp_en, exp_mem;
  logic [4:0]   exp_adrs;
  logic [W-1:0] exp_data;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    foreach (pend[i]) pend[i] = 1'b0;
    exp_en   = 1'b0;
    exp_mem  = 1'b0;
    exp_adrs = 5'd0;
    exp_data = '0;
  endtask

  function automatic bit exp_hit(input logic [4:0] a);
`ifdef WB_BYPASS_EN
    return exp_en && (exp_adrs == a) && (a != 5'd0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit exp_busy(input logic [4:0] a);
    return (a != 5'd0) && pend[a] && !exp_hit(a);
  endfunction

  task automatic idle();
    alu_valid = 1'b0;
    mem_valid = 1'b0;
    issue_en  = 1'b0;
  endtask

  // One clock: check combinational outputs, advance the model, then check wr_* after the edge.
  task automatic tick();
    ent_t         e;
    bit           acc, nen, nmem;
    logic [4:0]   nadrs;
    logic [W-1:0] ndata;
    #1;
    check("mem_ready", mem_ready, mq.size() < DEPTH);
    check("busy_a", busy_a, exp_busy(chk_adrs_a));
    check("busy_b", busy_b, exp_busy(chk_adrs_b));
`ifdef WB_BYPASS_EN
    check("fwd_hit_a", fwd_hit_a, exp_hit(chk_adrs_a));
    check("fwd_hit_b", fwd_hit_b, exp_hit(chk_adrs_b));
    if (exp_hit(chk_adrs_a)) check("fwd_a", fwd_a, exp_data);
    if (exp_hit(chk_adrs_b)) check("fwd_b", fwd_b, exp_data);
`endif
    acc   = mem_valid && (mq.size() < DEPTH);
    nen   = 1'b0;
    nmem  = 1'b0;
    nadrs = 5'd0;
    ndata = '0;
    if (alu_valid && alu_rd != 5'd0) begin
      nen   = 1'b1;
      nadrs = alu_rd;
      ndata = alu_data;
    end else if (mq.size() > 0) begin
      e = mq.pop_front();
      if (e.rd != 5'd0) begin
        nen   = 1'b1;
        nmem  = 1'b1;
        nadrs = e.rd;
        ndata = e.data;
      end
    end
    if (acc) begin
      e.rd   = mem_rd;
      e.data = mem_data;
      mq.push_back(e);
    end
    if (exp_en && exp_mem) pend[exp_adrs] = 1'b0;
    if (issue_en && issue_rd != 5'd0) pend[issue_rd] = 1'b1;
    exp_en   = nen;
    exp_mem  = nmem;
    exp_adrs = nadrs;
    exp_data = ndata;
    @(posedge clk_cpu);
    #1;
    check("wr_en", wr_en, exp_en);
    if (exp_en) begin
      check("wr_adrs", wr_adrs, exp_adrs);
      check("wr_data", wr_data, exp_data);
    end
  endtask

  initial begin
    reset      = 1'b1;
    idle();
    alu_rd     = 5'd0;
    alu_data   = '0;
    mem_rd     = 5'd0;
    mem_data   = '0;
    issue_rd   = 5'd0;
    chk_adrs_a = 5'd5;
    chk_adrs_b = 5'd0;
    model_reset();

    // Reset state
    @(posedge clk_cpu);
    @(posedge clk_cpu);
    #1;
    check("rst_wr_en", wr_en, 1'b0);
    check("rst_wr_adrs", wr_adrs, 5'd0);
    check("rst_wr_data", wr_data, '0);
    check("rst_mem_ready", mem_ready, 1'b1);
    check("rst_busy_a", busy_a, 1'b0);
    check("rst_busy_b", busy_b, 1'b0);
    reset = 1'b0;
    tick();

    // ALU write, then ALU with rd=0 dropped
    alu_valid = 1'b1;
    alu_rd    = 5'd5;
    alu_data  = 32'h11;
    tick();
    check("alu_wr_en", wr_en, 1'b1);
    check("alu_wr_adrs", wr_adrs, 5'd5);
    check("alu_wr_data", wr_data, 32'h11);
    alu_rd   = 5'd0;
    alu_data = 32'h22;
    tick();
    check("alu_rd0_wr_en", wr_en, 1'b0);

    // Fill the FIFO under ALU priority, then drain in order
    alu_valid = 1'b1;
    alu_rd    = 5'd1;
    for (int k = 0; k < 5; k++) begin
      alu_data  = 32'h500 + k;
      mem_valid = 1'b1;
      mem_rd    = 5'(10 + k);
      mem_data  = 32'h100 + k;
      tick();
    end
    check("full_mem_ready", mem_ready, 1'b0);
    idle();
    for (int k = 0; k < 4; k++) begin
      tick();
      check("drain_wr_en", wr_en, 1'b1);
      check("drain_wr_adrs", wr_adrs, 5'(10 + k));
      check("drain_wr_data", wr_data, 32'h100 + k);
    end
    tick();
    check("drained_wr_en", wr_en, 1'b0);

    // Pending bit set by issue, cleared at the edge after the memory write
    chk_adrs_a = 5'd7;
    issue_en   = 1'b1;
    issue_rd   = 5'd7;
    tick();
    idle();
    check("pend7_busy", busy_a, 1'b1);
    mem_valid = 1'b1;
    mem_rd    = 5'd7;
    mem_data  = 32'hAB;
    tick();
    idle();
    tick();
    check("mem7_wr_en", wr_en, 1'b1);
    check("mem7_wr_adrs", wr_adrs, 5'd7);
    check("mem7_wr_data", wr_data, 32'hAB);
`ifdef WB_BYPASS_EN
    check("fwd7_hit", fwd_hit_a, 1'b1);
    check("fwd7_data", fwd_a, 32'hAB);
    check("fwd7_busy", busy_a, 1'b0);
`else
    check("mem7_busy_during", busy_a, 1'b1);
`endif
    tick();
    check("mem7_busy_after", busy_a, 1'b0);

    // Re-issue on the commit edge keeps the bit set
    chk_adrs_a = 5'd9;
    issue_en   = 1'b1;
    issue_rd   = 5'd9;
    tick();
    idle();
    mem_valid = 1'b1;
    mem_rd    = 5'd9;
    mem_data  = 32'h99;
    tick();
    idle();
    tick();
    check("mem9_wr_en", wr_en, 1'b1);
    issue_en = 1'b1;
    issue_rd = 5'd9;
    tick();
    idle();
    check("pend9_kept", busy_a, 1'b1);
    tick();
    check("pend9_still", busy_a, 1'b1);

    // Mid-operation reset with 3 queued entries and pending {3,4}
    chk_adrs_a = 5'd3;
    chk_adrs_b = 5'd4;
    issue_en   = 1'b1;
    issue_rd   = 5'd3;
    tick();
    issue_rd = 5'd4;
    tick();
    idle();
    alu_valid = 1'b1;
    alu_rd    = 5'd2;
    for (int k = 0; k < 3; k++) begin
      alu_data  = 32'h700 + k;
      mem_valid = 1'b1;
      mem_rd    = 5'(20 + k);
      mem_data  = 32'h200 + k;
      tick();
    end
    check("pre_rst_busy_a", busy_a, 1'b1);
    check("pre_rst_busy_b", busy_b, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_wr_en", wr_en, 1'b0);
    check("async_rst_mem_ready", mem_ready, 1'b1);
    idle();
    @(posedge clk_cpu);
    #1;
    reset = 1'b0;
    model_reset();
    for (int k = 0; k < 4; k++) begin
      tick();
      check("post_rst_wr_en", wr_en, 1'b0);
      check("post_rst_mem_ready", mem_ready, 1'b1);
      check("post_rst_busy_a", busy_a, 1'b0);
      check("post_rst_busy_b", busy_b, 1'b0);
    end

    // Random traffic against the model
    for (int c = 0; c < 400; c++) begin
      alu_valid  = ($urandom_range(0, 2) == 0);
      alu_rd     = 5'($urandom_range(0, 31));
      alu_data   = $urandom;
      mem_valid  = ($urandom_range(0, 1) == 1);
      mem_rd     = 5'($urandom_range(0, 7));
      mem_data   = $urandom;
      issue_en   = ($urandom_range(0, 3) == 0);
      issue_rd   = 5'($urandom_range(0, 7));
      chk_adrs_a = 5'($urandom_range(0, 7));
      chk_adrs_b = 5'($urandom_range(0, 7));
      tick();
    end
    idle();
    for (int c = 0; c < 6; c++) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/writeback_arbiter.md
WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

Interface
REQ-001 The block SHALL use clock clk_cpu and reset reset, which is asynchronous and active-high.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4, giving the number of entries in the memory-result buffer; legal values are powers of two from 2 to 16.
REQ-003 Port clk_cpu  input  1  CPU clock.
REQ-004 Port reset  input  1  asynchronous active-high reset.
REQ-005 Port alu_valid / alu_rd / alu_data  input  1 / 5 / WORD  single-cycle ALU result; always accepted, no backpressure.
REQ-006 Port mem_valid / mem_rd / mem_data  input  1 / 5 / WORD  load/multi-cycle result offered via valid/ready.
REQ-007 Port mem_ready  output  1  buffer can accept a memory result this cycle.
REQ-008 Port issue_en / issue_rd  input  1 / 5  a long-latency op targeting issue_rd was issued; marks the register pending.
REQ-009 Port chk_adrs_a / chk_adrs_b  input  5 each  scoreboard query addresses, matched to the register-file read ports.
REQ-010 Port busy_a / busy_b  output  1 each  queried register has an outstanding memory result.
REQ-011 Port wr_adrs / wr_data / wr_en  output  5 / WORD / 1  register-file write port.

Function
REQ-012 wr_adrs, wr_data and wr_en SHALL be registered, one cycle after the winning source is selected.
REQ-013 The arbiter SHALL give the ALU absolute priority: alu_valid=1 with alu_rd!=0 drives the next wr_* from the ALU.
REQ-014 A memory result SHALL be accepted into the FIFO on mem_valid&&mem_ready; mem_ready SHALL be combinationally !full.
REQ-015 The FIFO head SHALL be popped to wr_* in any cycle where the ALU does not win and the FIFO is non-empty, preserving arrival order.
REQ-016 A result with rd=0 SHALL produce wr_en=0: an ALU result is dropped, and a memory entry is popped and discarded without a write.
REQ-017 Simultaneous push and pop SHALL be legal when full (no push) or when empty (no pop); the count SHALL stay in the range 0..FIFO_DEPTH.
REQ-018 The scoreboard SHALL hold 32 pending bits; issue_en with issue_rd!=0 SHALL set bit issue_rd at the clock edge.
REQ-019 A pending bit SHALL clear at the edge ending a cycle with wr_en=1 from a memory source for that address; this is the edge at which the register file commits the write.
REQ-020 If a set and a clear hit the same bit on the same edge, the set SHALL win.
REQ-021 ALU writes SHALL NOT modify the scoreboard.
REQ-022 busy_x SHALL combinationally equal pending[chk_adrs_x]; chk_adrs_x=0 SHALL always give busy_x=0.
REQ-023 wr_en SHALL be 0 in every cycle with no selected source.

Reset
REQ-024 On reset, wr_en, wr_adrs and wr_data SHALL be 0, the FIFO SHALL be empty, and all pending bits SHALL be 0.
REQ-025 During and immediately after reset, mem_ready SHALL be 1 and busy_a/busy_b SHALL be 0.
REQ-026 Reset asserted mid-operation SHALL discard buffered entries and the in-flight write; no write SHALL occur after reset deasserts.

Configuration
REQ-027 Macro WB_BYPASS_EN SHALL control the forwarding feature.
REQ-028 With WB_BYPASS_EN defined, the block SHALL add outputs fwd_hit_a/fwd_hit_b (1 bit each) and fwd_a/fwd_b (WORD each).
REQ-029 With WB_BYPASS_EN defined, fwd_hit_x SHALL equal wr_en && wr_adrs==chk_adrs_x && chk_adrs_x!=0, fwd_x SHALL equal wr_data, and busy_x SHALL equal pending[chk_adrs_x] && !fwd_hit_x.
REQ-030 Without WB_BYPASS_EN, these ports SHALL NOT exist and busy_x SHALL follow REQ-022.

Verification
REQ-031 The bench SHALL cover: ALU-only sequence alu_rd=5, data 0x11 -> wr_en=1, wr_adrs=5, wr_data=0x11 the next cycle; alu_rd=0 -> wr_en=0.
REQ-032 The bench SHALL cover: 5 memory results pushed while alu_valid is held high with FIFO_DEPTH=4 -> mem_ready=0 after 4 accepted; after ALU idles, wr_* shows the 4 results in order.
REQ-033 The bench SHALL cover: issue_rd=7, then memory result rd=7, data 0xAB -> busy=1 until the edge after wr_en=1 (adrs 7), and 0 afterwards.
REQ-034 The bench SHALL cover: issue_rd=9 on the same edge that a memory write to 9 commits -> bit 9 remains set.
REQ-035 The bench SHALL cover: reset pulsed with 3 FIFO entries and pending bits {3,4} -> no writes, mem_ready=1, busy=0 afterwards.
REQ-036 The bench SHALL cover, with WB_BYPASS_EN defined: chk_adrs_a=7 while wr_en=1, wr_adrs=7, data 0xAB -> fwd_hit_a=1, fwd_a=0xAB, busy_a=0.
